// File: rtl/inst_fetch_buf.sv
// ============================================================================
// inst_fetch_buf - in-order instruction fetch with redirect-aware buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_fetch_buf #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              inst_req_valid,
  input  logic              inst_req_ready,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [INST_W-1:0] inst_rdata,
  input  logic              inst_rvalid,
  output logic              inst_rready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int TAG_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_q, pend_d;
  logic              stale_q, stale_d;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic [OUT_W-1:0]  discard_q, discard_d;
  logic [ADDR_W-1:0] tag_q [MAX_OUT];
  logic [ADDR_W-1:0] tag_d [MAX_OUT];
  logic [TAG_W-1:0]  tag_wr_q, tag_wr_d;
  logic [TAG_W-1:0]  tag_rd_q, tag_rd_d;
  logic [INST_W-1:0] buf_inst_q [DEPTH];
  logic [INST_W-1:0] buf_inst_d [DEPTH];
  logic [ADDR_W-1:0] buf_pc_q [DEPTH];
  logic [ADDR_W-1:0] buf_pc_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       fetch_cnt_q, fetch_cnt_d;
  logic [31:0]       drop_cnt_q, drop_cnt_d;

  logic [31:0] occupancy;
  logic        can_issue;
  logic        fresh;
  logic        req_fire;
  logic        rsp;
  logic        drop;
  logic        push;
  logic        pop;

  // Outstanding requests reserve buffer slots so a response always has room.
  assign occupancy = 32'(outst_q) + 32'(count_q);
  assign can_issue = ~rst & ~stall & ~redirect_valid
                   & (outst_q < OUT_W'(MAX_OUT)) & (occupancy < 32'(DEPTH));
  assign fresh     = ~pend_q & can_issue;

  assign inst_req_valid = ~rst & (pend_q | can_issue);
  assign inst_addr      = pend_q ? pend_addr_q : fetch_pc_q;
  assign inst_rready    = 1'b1;

  assign req_fire = inst_req_valid & inst_req_ready;
  assign rsp      = inst_rvalid & (outst_q != '0);
  assign drop     = rsp & (redirect_valid | (discard_q != '0));
  assign push     = rsp & ~drop;

  assign out_valid      = (count_q != '0);
  assign out_inst       = buf_inst_q[head_q];
  assign out_pc         = buf_pc_q[head_q];
  assign pop            = out_valid & out_ready & ~redirect_valid;
  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pend_d      = inst_req_valid & ~inst_req_ready;
    pend_addr_d = pend_addr_q;
    stale_d     = stale_q;
    outst_d     = outst_q + OUT_W'(req_fire) - OUT_W'(rsp);
    discard_d   = discard_q;
    tag_d       = tag_q;
    tag_wr_d    = tag_wr_q;
    tag_rd_d    = tag_rd_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    fetch_cnt_d = fetch_cnt_q;
    drop_cnt_d  = drop_cnt_q;

    // The PC advances when an address is first presented; a held request keeps it.
    if (fresh) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end
    if (pend_d) begin
      pend_addr_d = inst_addr;
    end

    if (req_fire) begin
      tag_d[tag_wr_q] = inst_addr;
      tag_wr_d        = (tag_wr_q == TAG_W'(MAX_OUT - 1)) ? '0 : tag_wr_q + 1'b1;
      stale_d         = 1'b0;
    end
    if (rsp) begin
      tag_rd_d = (tag_rd_q == TAG_W'(MAX_OUT - 1)) ? '0 : tag_rd_q + 1'b1;
    end
    if (drop) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      stale_d    = pend_d;
      discard_d  = outst_d;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      discard_d = discard_q - OUT_W'(drop) + OUT_W'(req_fire & stale_q);
      if (push) begin
        buf_inst_d[tail_q] = inst_rdata;
        buf_pc_d[tail_q]   = tag_q[tag_rd_q];
        tail_d             = tail_q + 1'b1;
      end
      if (pop) begin
        head_d      = head_q + 1'b1;
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      stale_q     <= 1'b0;
      outst_q     <= '0;
      discard_q   <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      stale_q     <= stale_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q      <= tag_d;
    buf_inst_q <= buf_inst_d;
    buf_pc_q   <= buf_pc_d;
  end

endmodule

`default_nettype wire
